// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path.
// Contents:
//   drain_state_t - drain FSM states (IDLE, STREAM)
//   DEFAULT_DATA_WIDTH / DEFAULT_ARRAY_SIZE - default array geometry
//   acc_width()   - accumulator width for a given operand width and array size
package systolic_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } drain_state_t;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned DEFAULT_ARRAY_SIZE = 3;

   // Accumulator width: product width plus growth from summing N products.
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/drain_width_conv.sv
// Combinational width conversion from accumulator width to stream width.
// Build option: DRAIN_SATURATE_EN
//   defined   - values above 2^OUT_WIDTH-1 clamp to all-ones (unsigned)
//   undefined - plain truncation to the low OUT_WIDTH bits
// Ports:
//   acc    - accumulator element (IN_WIDTH bits, unsigned)
//   conv_c - converted element (OUT_WIDTH bits), combinational
module drain_width_conv #(
   parameter int unsigned IN_WIDTH  = 18,
   parameter int unsigned OUT_WIDTH = 16
) (
   input  logic [IN_WIDTH-1:0]  acc,
   output logic [OUT_WIDTH-1:0] conv_c
);

   generate
      if (IN_WIDTH > OUT_WIDTH) begin : g_narrow
         logic [IN_WIDTH-OUT_WIDTH-1:0] high_bits;
         assign high_bits = acc[IN_WIDTH-1:OUT_WIDTH];
`ifdef DRAIN_SATURATE_EN
         // Any bit set above the output range means the value does not fit.
         assign conv_c = (|high_bits) ? '1 : acc[OUT_WIDTH-1:0];
`else
         // High bits are intentionally dropped in truncation mode.
         logic unused_high;
         assign unused_high = ^high_bits;
         assign conv_c = acc[OUT_WIDTH-1:0];
`endif
      end else begin : g_pass
         // Equal widths: both modes are a straight pass-through.
         assign conv_c = OUT_WIDTH'(acc);
      end
   endgenerate

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain for systolic_array: snapshots the NxN accumulator grid on the
// rising edge of computation_done and streams it out row-major over a
// valid/ready interface, one element per accepted beat.
// Build option: DRAIN_SATURATE_EN (saturating instead of truncating out_data,
// resolved inside drain_width_conv).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   computation_done  - done level from the array (edge-detected here)
//   c_outputs         - NxN accumulator grid
//   out_valid/out_ready - stream handshake
//   out_data, out_row, out_col, out_last - beat payload
//   busy              - snapshot held / streaming
//   drain_done        - one-cycle pulse after the last beat is accepted
//   overrun           - sticky, done edge seen while busy
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = DEFAULT_DATA_WIDTH,
   parameter int unsigned ARRAY_SIZE        = DEFAULT_ARRAY_SIZE,
   parameter int unsigned ACCUMULATOR_WIDTH = acc_width(DATA_WIDTH, ARRAY_SIZE),
   parameter int unsigned OUT_WIDTH         = 16,
   parameter int unsigned IDX_WIDTH         = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         computation_done,
   input  logic [ACCUMULATOR_WIDTH-1:0] c_outputs [0:ARRAY_SIZE-1][0:ARRAY_SIZE-1],
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         out_data,
   output logic [IDX_WIDTH-1:0]         out_row,
   output logic [IDX_WIDTH-1:0]         out_col,
   output logic                         out_last,
   output logic                         busy,
   output logic                         drain_done,
   output logic                         overrun
);

   localparam logic [IDX_WIDTH-1:0] IDX_MAX = IDX_WIDTH'(ARRAY_SIZE - 1);

   drain_state_t                 state;
   logic                         done_q;
   logic                         armed;
   logic [ACCUMULATOR_WIDTH-1:0] buffer [0:ARRAY_SIZE-1][0:ARRAY_SIZE-1];

   logic                         done_rise_c;
   logic                         accept_c;
   logic [IDX_WIDTH-1:0]         next_row_c;
   logic [IDX_WIDTH-1:0]         next_col_c;
   logic [ACCUMULATOR_WIDTH-1:0] conv_in_c;
   logic [OUT_WIDTH-1:0]         conv_out_c;

   // Edge detect; armed masks the first cycle so a level already high at
   // reset release is not mistaken for a new edge.
   assign done_rise_c = computation_done & ~done_q & armed;
   assign accept_c    = out_valid & out_ready;

   // Index of the element that follows the one currently presented; the
   // converter sees the live grid on capture and the buffer while streaming.
   always_comb begin
      next_row_c = out_row;
      next_col_c = out_col + IDX_WIDTH'(1);
      if (out_col == IDX_MAX) begin
         next_col_c = '0;
         next_row_c = out_row + IDX_WIDTH'(1);
      end
      conv_in_c = buffer[next_row_c][next_col_c];
      if (state == IDLE) begin
         conv_in_c = c_outputs[0][0];
      end
   end

   drain_width_conv #(
      .IN_WIDTH  (ACCUMULATOR_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_width_conv (
      .acc    (conv_in_c),
      .conv_c (conv_out_c)
   );

   // Drain FSM, snapshot buffer and registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         done_q     <= 1'b0;
         armed      <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         drain_done <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            for (int j = 0; j < int'(ARRAY_SIZE); j++) begin
               buffer[i][j] <= '0;
            end
         end
      end else begin
         done_q     <= computation_done;
         armed      <= 1'b1;
         drain_done <= 1'b0;
         case (state)
            IDLE: begin
               if (done_rise_c) begin
                  for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
                     for (int j = 0; j < int'(ARRAY_SIZE); j++) begin
                        buffer[i][j] <= c_outputs[i][j];
                     end
                  end
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  out_data  <= conv_out_c;
                  out_row   <= '0;
                  out_col   <= '0;
                  out_last  <= (ARRAY_SIZE == 1);
                  overrun   <= 1'b0;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               // A new edge cannot be captured mid-stream; flag it instead.
               if (done_rise_c) begin
                  overrun <= 1'b1;
               end
               if (accept_c) begin
                  if (out_last) begin
                     out_valid  <= 1'b0;
                     busy       <= 1'b0;
                     out_data   <= '0;
                     out_row    <= '0;
                     out_col    <= '0;
                     out_last   <= 1'b0;
                     drain_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     out_data <= conv_out_c;
                     out_row  <= next_row_c;
                     out_col  <= next_col_c;
                     out_last <= (next_row_c == IDX_MAX) && (next_col_c == IDX_MAX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (N=3, 18-bit accumulators,
// 16-bit output). A queue/array model of the drained stream is compared with
// the DUT every cycle; directed tests add literal expectations.
module tb_systolic_result_drain;

   localparam int N  = 3;
   localparam int AW = 18;
   localparam int OW = 16;
   localparam int IW = 2;

   typedef struct {
      logic [OW-1:0] d;
      logic [IW-1:0] r;
      logic [IW-1:0] c;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          computation_done;
   logic [AW-1:0] c_out [0:N-1][0:N-1];
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic [IW-1:0] out_row;
   logic [IW-1:0] out_col;
   logic          out_last;
   logic          busy;
   logic          drain_done;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   // Model: snapshot copy, beats remaining, position in row-major order.
   logic [AW-1:0] snap [0:N-1][0:N-1];
   int            m_rem;
   int            m_pos;
   bit            m_prev, m_armed, m_ovr, m_drain, m_rise;
   beat_t         acc_q[$];

   always #5 clk = ~clk;

   systolic_result_drain dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .computation_done (computation_done),
      .c_outputs        (c_out),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_row          (out_row),
      .out_col          (out_col),
      .out_last         (out_last),
      .busy             (busy),
      .drain_done       (drain_done),
      .overrun          (overrun)
   );

   function automatic logic [OW-1:0] conv(input logic [AW-1:0] v);
`ifdef DRAIN_SATURATE_EN
      return (v > 18'h0FFFF) ? 16'hFFFF : v[OW-1:0];
`else
      return v[OW-1:0];
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour: edge capture, row-major drain, sticky overrun.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem = 0; m_pos = 0; m_prev = 0; m_armed = 0; m_ovr = 0; m_drain = 0;
      end else begin
         m_rise  = computation_done && !m_prev && m_armed;
         m_prev  = computation_done;
         m_armed = 1;
         m_drain = 0;
         if (m_rem == 0) begin
            if (m_rise) begin
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++) snap[i][j] = c_out[i][j];
               m_pos = 0; m_rem = N * N; m_ovr = 0;
            end
         end else begin
            if (m_rise) m_ovr = 1;
            if (out_ready) begin
               m_pos++; m_rem--;
               if (m_rem == 0) m_drain = 1;
            end
         end
      end
   end

   // Record every beat the DUT hands over (pre-edge values).
   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready)
         acc_q.push_back('{d: out_data, r: out_row, c: out_col, l: out_last});
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", 32'(out_valid), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_drain", 32'(drain_done), 0);
         chk("rst_overrun", 32'(overrun), 0);
         chk("rst_data", 32'(out_data), 0);
         chk("rst_last", 32'(out_last), 0);
      end else begin
         chk("valid", 32'(out_valid), 32'(m_rem > 0));
         chk("busy", 32'(busy), 32'(m_rem > 0));
         chk("drain_done", 32'(drain_done), 32'(m_drain));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         if (m_rem > 0) begin
            chk("data", 32'(out_data), 32'(conv(snap[m_pos / N][m_pos % N])));
            chk("row", 32'(out_row), m_pos / N);
            chk("col", 32'(out_col), m_pos % N);
            chk("last", 32'(out_last), 32'(m_pos == N * N - 1));
         end
      end
   end

   task automatic load_grid(input int base);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) c_out[i][j] = AW'(base + i * N + j);
   endtask

   // Advance until the model stream has drained, with a cycle budget.
   task automatic run_until_idle(input int budget, input bit toggle_ready);
      int k;
      k = 0;
      while (m_rem != 0 && k < budget) begin
         @(negedge clk);
         if (toggle_ready) out_ready = (k % 3 == 0);
         k++;
      end
      if (m_rem != 0) begin
         chk("stream_timeout", 32'(m_rem), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   // Single-cycle done pulse starting at a negedge.
   task automatic pulse_done();
      @(negedge clk); computation_done = 1'b1;
      @(negedge clk); computation_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; computation_done = 1'b0; out_ready = 1'b0;
      load_grid(0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // T1: grid 1..9, ready always high -> 9 back-to-back beats.
      load_grid(1); out_ready = 1'b1; acc_q.delete();
      pulse_done();
      run_until_idle(40, 1'b0);
      chk("t1_count", 32'(acc_q.size()), 9);
      chk("t1_b0_data", 32'(acc_q[0].d), 1);
      chk("t1_b0_last", 32'(acc_q[0].l), 0);
      chk("t1_b4_rowcol", {28'd0, acc_q[4].r, acc_q[4].c}, 32'h5);
      chk("t1_b7_last", 32'(acc_q[7].l), 0);
      chk("t1_b8_data", 32'(acc_q[8].d), 9);
      chk("t1_b8_rowcol", {28'd0, acc_q[8].r, acc_q[8].c}, 32'hA);
      chk("t1_b8_last", 32'(acc_q[8].l), 1);
      chk("t1_busy_after", 32'(busy), 0);

      // T2: same data, ready pattern 1,0,0 -> stalls hold the beat.
      acc_q.delete(); out_ready = 1'b0;
      pulse_done();
      run_until_idle(80, 1'b1);
      chk("t2_count", 32'(acc_q.size()), 9);
      for (int i = 0; i < acc_q.size(); i++) chk("t2_order", 32'(acc_q[i].d), i + 1);

      // T3: second edge during beat 4 -> overrun, original data kept.
      load_grid(10); acc_q.delete(); out_ready = 1'b1;
      pulse_done();
      repeat (3) @(negedge clk);
      computation_done = 1'b1;
      @(negedge clk);
      computation_done = 1'b0;
      load_grid(100);
      chk("t3_overrun_set", 32'(overrun), 1);
      run_until_idle(40, 1'b0);
      chk("t3_count", 32'(acc_q.size()), 9);
      chk("t3_b3_data", 32'(acc_q[3].d), 13);
      chk("t3_b8_data", 32'(acc_q[8].d), 18);
      chk("t3_overrun_sticky", 32'(overrun), 1);
      acc_q.delete();
      pulse_done();
      chk("t3_overrun_clear", 32'(overrun), 0);
      chk("t3_new_data", 32'(out_data), 100);
      run_until_idle(40, 1'b0);

      // T4: done held high 20 cycles -> exactly one stream.
      load_grid(20); acc_q.delete();
      @(negedge clk); computation_done = 1'b1;
      repeat (20) @(negedge clk);
      computation_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("t4_count", 32'(acc_q.size()), 9);
      chk("t4_valid_after", 32'(out_valid), 0);

      // T5: width conversion of oversized elements.
      load_grid(0);
      c_out[0][0] = 18'h2ABCD; c_out[0][1] = 18'h10000; c_out[1][1] = 18'h0FFFF;
      acc_q.delete();
      pulse_done();
      run_until_idle(40, 1'b0);
`ifdef DRAIN_SATURATE_EN
      chk("t5_big", 32'(acc_q[0].d), 32'hFFFF);
      chk("t5_2p16", 32'(acc_q[1].d), 32'hFFFF);
`else
      chk("t5_big", 32'(acc_q[0].d), 32'hABCD);
      chk("t5_2p16", 32'(acc_q[1].d), 32'h0000);
`endif
      chk("t5_max_fit", 32'(acc_q[4].d), 32'hFFFF);

      // T6: async reset after beat 5, with overrun set and done held high.
      load_grid(1); acc_q.delete();
      @(negedge clk); computation_done = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) computation_done = 1'b0;
         if (k == 2) computation_done = 1'b1;
      end
      chk("t6_beats_before", 32'(acc_q.size()), 5);
      chk("t6_overrun_pre", 32'(overrun), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(out_valid), 0);
      chk("t6_async_busy", 32'(busy), 0);
      chk("t6_async_overrun", 32'(overrun), 0);
      chk("t6_async_drain", 32'(drain_done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; acc_q.delete();
      repeat (6) @(negedge clk);
      chk("t6_no_resume", 32'(acc_q.size()), 0);
      chk("t6_idle_valid", 32'(out_valid), 0);
      computation_done = 1'b0;
      pulse_done();
      run_until_idle(40, 1'b0);
      chk("t6_restart_count", 32'(acc_q.size()), 9);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output-side companion to systolic_array; reads results out of the array's result port.
- On the rising edge of computation_done, snapshots the NxN c_outputs accumulator grid into a local buffer.
- Streams the buffered results out one element per accepted beat, row-major, over a valid/ready interface.
- Releases the array for the next computation as soon as the snapshot is taken.

Parameters:
- DATA_WIDTH, 8, operand width of the systolic array.
- ARRAY_SIZE, 3, array dimension N (NxN results).
- ACCUMULATOR_WIDTH, 2*DATA_WIDTH+$clog2(ARRAY_SIZE), width of each c_outputs element.
- OUT_WIDTH, 16, width of out_data; must be <= ACCUMULATOR_WIDTH.
- IDX_WIDTH, (ARRAY_SIZE>1 ? $clog2(ARRAY_SIZE) : 1), width of the row/column index.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- computation_done, input, 1, done flag from systolic_array; level, may stay high.
- c_outputs, input, ACCUMULATOR_WIDTH x [0:ARRAY_SIZE-1][0:ARRAY_SIZE-1], unpacked result grid.
- out_valid, output, 1, out_data/out_row/out_col/out_last are valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, OUT_WIDTH, result element.
- out_row, output, IDX_WIDTH, row index i of out_data.
- out_col, output, IDX_WIDTH, column index j of out_data.
- out_last, output, 1, marks the element [N-1][N-1].
- busy, output, 1, high while a snapshot is held or streaming.
- drain_done, output, 1, one-cycle pulse after the last beat is accepted.
- overrun, output, 1, sticky; a done edge arrived while busy.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; buffer cleared to 0; done-edge history register=0.
- Edge detect: done_rise = computation_done & ~done_q. done_q is registered every cycle. A done level already high at reset release produces no edge.
- State IDLE:
  - On done_rise, load all N*N c_outputs into the buffer in that cycle.
  - Clear row/col counters and go to STREAM.
  - out_valid rises the next cycle (capture-to-first-valid latency = 1 cycle).
- State STREAM:
  - out_valid=1, busy=1.
  - out_data is buffer[row][col] after width conversion; out_row=row, out_col=col.
  - out_last=1 only when row==N-1 and col==N-1.
  - Beat accepted when out_valid & out_ready. Then col increments; at col==N-1, col wraps to 0 and row increments.
  - Without acceptance, all out_* stay stable (AXI-stream style; valid never drops before acceptance).
  - Acceptance with out_last: go to IDLE; out_valid=0 next cycle; drain_done pulses for exactly 1 cycle in that next cycle.
  - Full throughput: out_ready held high gives N*N consecutive beats with no bubbles.
- Overrun: done_rise while in STREAM is ignored; the buffer is not overwritten and overrun is set.
  - overrun clears only on reset or on the next accepted snapshot in IDLE.
- Simultaneous last-beat acceptance and done_rise: the edge is lost (counts as overrun). The next capture requires a fresh edge.
- Width rule: out_data = buffer element truncated to the low OUT_WIDTH bits (see Optional Feature).
- Reset mid-stream: aborts immediately; no drain_done pulse; the stream is not resumed.
- Values treated as unsigned throughout.

Optional Feature:
- Macro: DRAIN_SATURATE_EN.
- Defined: an element greater than 2^OUT_WIDTH-1 outputs all-ones (unsigned clamp).
- Undefined: plain truncation to the low OUT_WIDTH bits.
- Identical behaviour when OUT_WIDTH == ACCUMULATOR_WIDTH.

Decomposition:
- Shared package systolic_pkg:
  - drain_state_t enum (IDLE, STREAM).
  - default DATA_WIDTH/ARRAY_SIZE constants.
  - function acc_width(dw, n) returning 2*dw+$clog2(n).
- One natural sub-module, drain_width_conv: the combinational truncate/saturate stage, with the macro resolved inside it.
- The FSM, counters and buffer stay in the top module.

Test Plan:
- A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, out_ready=1 -> 9 back-to-back beats 1..9 with (row,col) (0,0)..(2,2); out_last only on the 9th beat (value 9); drain_done pulses 1 cycle later; busy low after.
- Same data with out_ready toggling 1,0,0,1,... -> out_data/out_row/out_col stable while stalled; exactly 9 accepted beats, no duplicates, order preserved.
- Second done edge during beat 4 of a stream -> overrun=1; remaining beats carry the original data; overrun clears on the next capture after re-asserting done.
- computation_done held high for 20 cycles -> exactly one 9-beat stream; no restart.
- c_outputs[0][0]=18'h2ABCD, OUT_WIDTH=16 -> out_data 16'hABCD without DRAIN_SATURATE_EN; 16'hFFFF with it.
- rst_n asserted after beat 5 -> out_valid, busy, overrun and drain_done go to 0 asynchronously; after release, no output until a new done edge.
